mem_access_seq: RTL and testbench

//  Load/store sequencer directly upstream of the byte-wide data memory (dram).

---
 rtl/mem_access_seq.sv | 105 ++++++++++
 tb/tb_mem_access_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: splits core word/byte loads and stores into byte-wide dram cycles.
// Word loads use the dram's 12/20-bit partial read ports; word stores are four big-endian byte writes.
module mem_access_seq #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    mem_sel,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [11:0]   mem_lo12,
   input  logic [19:0]   mem_up20,
   input  logic [7:0]    mem_byte
);
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RD_WAIT, RD_B, RD_BWAIT, WR, RESP} state_t;
   state_t state, state_nx;
   logic [AW-1:0] addr;
   logic          byte_op;
   logic [31:0]   wdata;
   logic [1:0]    cnt;
   logic [11:0]   lo;
   logic          accept, bad;
   assign accept = req_valid && state == IDLE;
   // word ops whose last byte would fall off the end of the dram are rejected
   assign bad = !req_op[0] && req_addr > AW'('h3FC);
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_sel   = 2'b11;
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_wdata = wdata[7:0];
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nx = bad ? RESP : req_op == 2'b00 ? RD_LO : req_op == 2'b01 ? RD_B : WR;
         end
         RD_LO: begin
            mem_sel  = 2'b00;
            state_nx = RD_HI;
         end
         RD_HI: begin
            mem_sel  = 2'b01;
            state_nx = RD_WAIT;
         end
         RD_WAIT:  state_nx = RESP;
         RD_B: begin
            mem_sel  = 2'b10;
            state_nx = RD_BWAIT;
         end
         RD_BWAIT: state_nx = RESP;
         WR: begin
            mem_we    = 1'b1;
            mem_addr  = addr + AW'(cnt);
            mem_wdata = byte_op ? wdata[7:0] : 8'(wdata >> {~cnt, 3'b000});
            if (byte_op || cnt == 2'd3)
               state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         byte_op   <= 1'b0;
         wdata     <= '0;
         cnt       <= '0;
         lo        <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr      <= req_addr;
            byte_op   <= req_op[0];
            wdata     <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= bad;
         end
         cnt <= state == WR ? cnt + 2'd1 : 2'd0;
         if (state == RD_HI)
            lo <= mem_lo12;
         if (state == RD_WAIT)
            rsp_rdata <= {lo, mem_up20};
         if (state == RD_BWAIT)
            rsp_rdata <= {{24{mem_byte[7]}}, mem_byte};
      end
   end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed plus randomized requests against a byte-array dram and a
// request-level reference memory that predicts load data, latency and write sequence.
module tb_mem_access_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [9:0]  mem_addr;
   logic [1:0]  mem_sel;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [11:0] mem_lo12 = '0;
   logic [19:0] mem_up20 = '0;
   logic [7:0]  mem_byte = '0;
   logic [7:0]  mem [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] last_rdata;
   int          vectors = 0;
   int          miscompares = 0;

   mem_access_seq #(.AW(10)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_lo12(mem_lo12), .mem_up20(mem_up20), .mem_byte(mem_byte)
   );

   always #5 clk = ~clk;

   // dram: registered partial reads of the big-endian word at the address
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_sel == 2'b00) mem_lo12 <= {mem[mem_addr], mem[mem_addr + 10'd1][7:4]};
      if (mem_sel == 2'b01) mem_up20 <= {mem[mem_addr + 10'd1][3:0], mem[mem_addr + 10'd2], mem[mem_addr + 10'd3]};
      if (mem_sel == 2'b10) mem_byte <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [9:0] a, input logic [7:0] d);
      mem[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic req(input logic [1:0] op, input logic [9:0] a, input logic [31:0] wd);
      logic        err;
      int          lat, nw, rsp_n, rsp_at, we_n;
      logic [31:0] exp_d, got_d;
      logic        got_e;
      err = !op[0] && a > 10'h3FC;
      lat = err ? 1 : op == 2'd0 ? 4 : op == 2'd1 ? 3 : op == 2'd2 ? 5 : 2;
      nw = (err || !op[1]) ? 0 : op[0] ? 1 : 4;
      exp_d = (err || op[1]) ? 32'h0 : op[0] ? {{24{ref_mem[a][7]}}, ref_mem[a]}
            : {ref_mem[a], ref_mem[a + 10'd1], ref_mem[a + 10'd2], ref_mem[a + 10'd3]};
      @(negedge clk);
      check("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 2'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;
      rsp_n = 0; rsp_at = 0; we_n = 0; got_d = '0; got_e = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rsp_n++;
            if (rsp_at == 0) begin
               rsp_at = c; got_d = rsp_rdata; got_e = rsp_err;
            end
         end
         if (mem_we) begin
            check("wr_addr", mem_addr, a + 10'(we_n));
            check("wr_data", mem_wdata, op[0] ? wd[7:0] : wd[31 - 8*we_n -: 8]);
            we_n++;
         end
      end
      check("rsp_count", rsp_n, 1);
      check("rsp_cycle", rsp_at, lat);
      check("rsp_rdata", got_d, exp_d);
      check("rsp_err", got_e, err);
      check("we_count", we_n, nw);
      if (!err && op == 2'd2)
         for (int k = 0; k < 4; k++) ref_mem[a + 10'(k)] = wd[31 - 8*k -: 8];
      if (op == 2'd3) ref_mem[a] = wd[7:0];
      last_rdata = got_d;
   endtask

   initial begin
      int bad_bytes;
      for (int i = 0; i < 1024; i++) poke(10'(i), 8'($urandom));
      #12;
      check("rst_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_mem_sel", mem_sel, 2'b11);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      poke(10'h010, 8'hDE); poke(10'h011, 8'hAD); poke(10'h012, 8'hBE); poke(10'h013, 8'hEF);
      req(2'd0, 10'h010, 32'h0);
      check("lw_deadbeef", last_rdata, 32'hDEADBEEF);
      req(2'd2, 10'h3FC, 32'h12345678);
      req(2'd0, 10'h3FC, 32'h0);
      check("lw_3fc", last_rdata, 32'h12345678);
      req(2'd3, 10'h3FF, 32'hFFFF_FFA5);
      req(2'd1, 10'h3FF, 32'h0);
      check("lb_neg", last_rdata, 32'hFFFFFFA5);
      req(2'd3, 10'h100, 32'h0000_007F);
      req(2'd1, 10'h100, 32'h0);
      check("lb_pos", last_rdata, 32'h0000007F);
      req(2'd0, 10'h3FD, 32'h0);
      req(2'd2, 10'h3FE, 32'hCAFEF00D);
      req(2'd2, 10'h3FF, 32'hCAFEF00D);

      // valid held high across two loads: second acceptance only once idle again
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd0; req_addr = 10'h010;
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) @(negedge clk);
         check("b2b_ready", req_ready, n == 0 || n == 5 || n == 10);
         check("b2b_rsp", rsp_valid, n == 4 || n == 9);
      end
      req_valid = 1'b0;
      repeat (2) @(negedge clk);

      // reset during the second byte of a word store
      req_op = 2'd2; req_addr = 10'h020; req_wdata = 32'h55667788; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_we_async", mem_we, 0);
      check("rst_ready_mid", req_ready, 1);
      check("rst_sel_mid", mem_sel, 2'b11);
      check("rst_addr_mid", mem_addr, 0);
      ref_mem[10'h020] = 8'h55;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("rst_no_rsp", rsp_valid, 0);
      end
      check("rst_byte0", mem[10'h020], 8'h55);
      check("rst_byte1", mem[10'h021], ref_mem[10'h021]);

      for (int i = 0; i < 60; i++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(10'h3F8, 10'h3FF)) : 10'($urandom);
         req(2'($urandom), a, $urandom);
      end

      bad_bytes = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
      check("mem_image", bad_bytes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
